// File: rtl/calc_err.sv
`default_nettype none
// ============================================================================
// Module   : calc_err
// Purpose  : Error-generation datapath for an LMS system-identification loop.
//            A fixed first-order IIR reference plant and a feed-forward
//            estimator built from the adaptive coefficients a_hat/b_hat both
//            advance on every clock. A registered error stage produces
//            e = y_cur - y_hat from the previous cycle's plant and estimator
//            outputs.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  asynchronous active-low reset
//   x_last  in   W  signed input sample x[n-1]
//   y_init  in   W  signed plant initial condition y[0]
//   a_hat   in   W  signed estimated feedback coefficient
//   b_hat   in   W  signed estimated input coefficient
//   y_last  out  W  signed plant output y[n-1] (registered)
//   y_cur   out  W  signed plant output y[n] (registered)
//   y_hat   out  W  signed estimator output (registered)
//   e       out  W  signed error y_cur - y_hat (registered)
//   e_valid out  1  e reflects a post-reset sample
// ----------------------------------------------------------------------------
// Build option
//   CALC_ERR_SAT_EN : when defined, y_cur, y_hat and e saturate to the signed
//                     W-bit range; otherwise they keep the low W bits (wrap).
// ============================================================================
module calc_err #(
  parameter int W      = 8,
  parameter int A_COEF = 1,
  parameter int B_COEF = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x_last,
  input  logic [W-1:0] y_init,
  input  logic [W-1:0] a_hat,
  input  logic [W-1:0] b_hat,
  output logic [W-1:0] y_last,
  output logic [W-1:0] y_cur,
  output logic [W-1:0] y_hat,
  output logic [W-1:0] e,
  output logic         e_valid
);

`ifdef CALC_ERR_SAT_EN
  localparam logic c_sat = 1'b1;
`else
  localparam logic c_sat = 1'b0;
`endif

  localparam logic [W-1:0] c_a   = A_COEF[W-1:0];
  localparam logic [W-1:0] c_b   = B_COEF[W-1:0];
  localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

  // Sign-extended 2W-bit coefficient copies so every product is full width.
  localparam logic signed [2*W-1:0] c_a2 = {{W{c_a[W-1]}}, c_a};
  localparam logic signed [2*W-1:0] c_b2 = {{W{c_b[W-1]}}, c_b};

  logic [W-1:0] r_y_last;
  logic [W-1:0] r_y_cur;
  logic [W-1:0] r_y_hat;
  logic [W-1:0] r_e;
  logic         r_e_valid;
  logic         r_started;

  // Operand select: the initial condition seeds the first edge only.
  logic [W-1:0] w_yp;
  assign w_yp = r_started ? r_y_cur : y_init;

  logic signed [2*W-1:0] w_yp2, w_x2, w_ah2, w_bh2;
  assign w_yp2 = {{W{w_yp[W-1]}}, w_yp};
  assign w_x2  = {{W{x_last[W-1]}}, x_last};
  assign w_ah2 = {{W{a_hat[W-1]}}, a_hat};
  assign w_bh2 = {{W{b_hat[W-1]}}, b_hat};

  logic signed [2*W-1:0] w_pa, w_pb, w_ha, w_hb;
  assign w_pa = c_a2  * w_yp2;
  assign w_pb = c_b2  * w_x2;
  assign w_ha = w_ah2 * w_yp2;
  assign w_hb = w_bh2 * w_x2;

  // 2W+1-bit sums cannot overflow for any W-bit operands.
  logic [2*W:0] w_ysum, w_hsum;
  assign w_ysum = {w_pa[2*W-1], w_pa} + {w_pb[2*W-1], w_pb};
  assign w_hsum = {w_ha[2*W-1], w_ha} + {w_hb[2*W-1], w_hb};

  logic [W:0] w_ediff;
  assign w_ediff = {r_y_cur[W-1], r_y_cur} - {r_y_hat[W-1], r_y_hat};

  // A value fits in W signed bits iff every bit above the W-bit sign bit
  // matches it.
  logic w_ysum_ovf, w_hsum_ovf, w_ediff_ovf;
  assign w_ysum_ovf  = !((&w_ysum[2*W:W-1]) || !(|w_ysum[2*W:W-1]));
  assign w_hsum_ovf  = !((&w_hsum[2*W:W-1]) || !(|w_hsum[2*W:W-1]));
  assign w_ediff_ovf = !((&w_ediff[W:W-1])  || !(|w_ediff[W:W-1]));

  logic [W-1:0] w_y_cur_nx, w_y_hat_nx, w_e_nx;
  always_comb begin
    w_y_cur_nx = w_ysum[W-1:0];
    w_y_hat_nx = w_hsum[W-1:0];
    w_e_nx     = w_ediff[W-1:0];
    if (c_sat && w_ysum_ovf)  w_y_cur_nx = w_ysum[2*W] ? c_min : c_max;
    if (c_sat && w_hsum_ovf)  w_y_hat_nx = w_hsum[2*W] ? c_min : c_max;
    if (c_sat && w_ediff_ovf) w_e_nx     = w_ediff[W]  ? c_min : c_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y_last  <= '0;
      r_y_cur   <= '0;
      r_y_hat   <= '0;
      r_e       <= '0;
      r_e_valid <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_y_last  <= w_yp;
      r_y_cur   <= w_y_cur_nx;
      r_y_hat   <= w_y_hat_nx;
      r_e       <= w_e_nx;
      r_e_valid <= r_started;
      r_started <= 1'b1;
    end
  end

  assign y_last  = r_y_last;
  assign y_cur   = r_y_cur;
  assign y_hat   = r_y_hat;
  assign e       = r_e;
  assign e_valid = r_e_valid;

endmodule
`default_nettype wire

// File: tb/tb_calc_err.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_err
// Purpose  : Directed, table-driven bench for calc_err (W=8, A=1, B=2).
//            Each table row is one clock edge: optional reset pulse before it,
//            input values, and hand-computed register values after the edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_err;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] x_last, y_init, a_hat, b_hat;
  logic [W-1:0] y_last, y_cur, y_hat, e;
  logic         e_valid;

  int checks = 0;
  int errors = 0;

  calc_err #(.W(W), .A_COEF(1), .B_COEF(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .x_last  (x_last),
    .y_init  (y_init),
    .a_hat   (a_hat),
    .b_hat   (b_hat),
    .y_last  (y_last),
    .y_cur   (y_cur),
    .y_hat   (y_hat),
    .e       (e),
    .e_valid (e_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rst_first;
    logic [W-1:0] x, yi, a, b;
    logic [W-1:0] yl, yc, yh, ee;
    logic         ev;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit r, input int x, input int yi, input int a,
                      input int b, input int yl, input int yc, input int yh,
                      input int ee, input bit ev);
    vec_t t;
    t.rst_first = r;
    t.x  = x[W-1:0];
    t.yi = yi[W-1:0];
    t.a  = a[W-1:0];
    t.b  = b[W-1:0];
    t.yl = yl[W-1:0];
    t.yc = yc[W-1:0];
    t.yh = yh[W-1:0];
    t.ee = ee[W-1:0];
    t.ev = ev;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] yl,
                         input logic [W-1:0] yc, input logic [W-1:0] yh,
                         input logic [W-1:0] ee, input logic ev);
    chk({tag, ".y_last"}, y_last, yl);
    chk({tag, ".y_cur"},  y_cur,  yc);
    chk({tag, ".y_hat"},  y_hat,  yh);
    chk({tag, ".e"},      e,      ee);
    chk({tag, ".e_valid"}, {{(W-1){1'b0}}, e_valid}, {{(W-1){1'b0}}, ev});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Mismatched coefficients: y_init=0, a=b=0, x=2,1,2
    addv(1, 2, 0, 0, 0,   0,  4, 0, 0, 0);
    addv(0, 1, 0, 0, 0,   4,  6, 0, 4, 1);
    addv(0, 2, 0, 0, 0,   6, 10, 0, 6, 1);
    // Matched coefficients: a=1, b=2, x alternating 2,1
    addv(1, 2, 0, 1, 2,   0,  4,  4, 0, 0);
    addv(0, 1, 0, 1, 2,   4,  6,  6, 0, 1);
    addv(0, 2, 0, 1, 2,   6, 10, 10, 0, 1);
    addv(0, 1, 0, 1, 2,  10, 12, 12, 0, 1);
    // Initial condition; y_init changes after edge1 are ignored
    addv(1, 0,  3, 0, 0,  3, 3, 0, 0, 0);
    addv(0, 0, 50, 0, 0,  3, 3, 0, 3, 1);
    addv(0, 0, -7, 0, 0,  3, 3, 0, 3, 1);
    // Overflow on the plant path: x=100 held
`ifdef CALC_ERR_SAT_EN
    addv(1, 100, 0, 0, 0,    0, 127, 0,   0, 0);
    addv(0, 100, 0, 0, 0,  127, 127, 0, 127, 1);
`else
    addv(1, 100, 0, 0, 0,    0,  -56, 0,   0, 0);
    addv(0, 100, 0, 0, 0,  -56, -112, 0, -56, 1);
`endif
    // Mixed coefficients: a=2, b=1, x alternating 2,1
    addv(1, 2, 0, 2, 1,   0,  4,  2,  0, 0);
    addv(0, 1, 0, 2, 1,   4,  6,  9,  2, 1);
    addv(0, 2, 0, 2, 1,   6, 10, 14, -3, 1);
    addv(0, 1, 0, 2, 1,  10, 12, 21, -4, 1);
    // Estimator overflow and error-difference overflow (b_hat=-128)
`ifdef CALC_ERR_SAT_EN
    addv(1, 1, 0, 0, -128,  0, 2, -128,   0, 0);
    addv(0, 2, 0, 0, -128,  2, 6, -128, 127, 1);
    addv(0, 0, 0, 0, -128,  6, 6,    0, 127, 1);
`else
    addv(1, 1, 0, 0, -128,  0, 2, -128,    0, 0);
    addv(0, 2, 0, 0, -128,  2, 6,    0, -126, 1);
    addv(0, 0, 0, 0, -128,  6, 6,    0,    6, 1);
`endif

    // Held reset with random inputs, including across clock edges
    rst    = 1'b0;
    x_last = W'($urandom);
    y_init = W'($urandom);
    a_hat  = W'($urandom);
    b_hat  = W'($urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
      x_last = W'($urandom);
      y_init = W'($urandom);
      a_hat  = W'($urandom);
      b_hat  = W'($urandom);
    end
    chk_all("held_reset", 0, 0, 0, 0, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) pulse_reset();
      else @(negedge clk);
      x_last = vecs[i].x;
      y_init = vecs[i].yi;
      a_hat  = vecs[i].a;
      b_hat  = vecs[i].b;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].yl, vecs[i].yc, vecs[i].yh,
              vecs[i].ee, vecs[i].ev);
    end

    // Mid-run asynchronous reset: state is non-zero here; assert reset away
    // from any clock edge and check outputs clear before the next edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    #2;
    // Restart: started must be cleared, so y_init seeds again and e_valid=0.
    rst    = 1'b1;
    x_last = '0;
    y_init = W'(5);
    a_hat  = '0;
    b_hat  = '0;
    @(posedge clk);
    #1;
    chk_all("restart1", 5, 5, 0, 0, 0);
    y_init = W'(9);
    @(posedge clk);
    #1;
    chk_all("restart2", 5, 5, 0, 5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_err.md
Name: calc_err

Overview:
- Error-generation datapath for the LMS system-identification loop.
- Contains three parts:
  - a reference plant (first-order IIR, fixed coefficients), which advances on every clock;
  - a feed-forward estimator using the adaptive coefficients a_hat/b_hat, which also advances on every clock;
  - a registered error stage, e = y - y_hat.
- Sits between the stimulus source and the LMS coefficient-update block, which consumes e, y_last and x_last.

Parameters:
- W, 8: data width of all signed samples, coefficients and outputs.
- A_COEF, 1: plant feedback coefficient (signed, W bits).
- B_COEF, 2: plant input coefficient (signed, W bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- x_last  in  W  signed input sample x[n-1].
- y_init  in  W  signed plant initial condition y[0].
- a_hat  in  W  signed estimated feedback coefficient.
- b_hat  in  W  signed estimated input coefficient.
- y_last  out  W  signed plant output y[n-1] (registered).
- y_cur  out  W  signed plant output y[n] (registered).
- y_hat  out  W  signed estimator output (registered).
- e  out  W  signed error, y_cur - y_hat (registered).
- e_valid  out  1  high when e reflects a post-reset sample.

Behaviour:
- Reset (rst=0, asynchronous): y_last, y_cur, y_hat and e are 0; e_valid=0; internal flag started=0. Outputs clear immediately, including when reset is asserted mid-operation.
- Operand select: yp = y_init when started=0, else y_cur.
- Each rising edge with rst=1, all updates take effect simultaneously:
  - y_last <= yp
  - y_cur <= A_COEF*yp + B_COEF*x_last
  - y_hat <= a_hat*yp + b_hat*x_last
  - e <= y_cur - y_hat, using the pre-edge register values
  - e_valid <= started
  - started <= 1
- Latency:
  - x_last sampled at edge k appears in y_cur and y_hat after edge k.
  - The resulting error appears after edge k+1.
  - e_valid first rises after the 2nd edge following reset release.
- Arithmetic:
  - All operands are two's-complement signed.
  - Products are computed at full 2W-bit precision; sums at 2W+1 bits.
  - Error difference is computed at W+1 bits.
  - Default result reduction: keep the low W bits (wrap-around).
- Inputs x_last, a_hat, b_hat and y_init are sampled only at clock edges; no handshake.
- y_init is used only on the first edge after reset release; it is ignored afterwards.
- If a_hat=A_COEF and b_hat=B_COEF, then y_hat equals y_cur every cycle, so e=0 whenever e_valid=1.

Optional Feature:
- Macro CALC_ERR_SAT_EN.
- When defined: the y_cur, y_hat and e results saturate to [-2^(W-1), 2^(W-1)-1] instead of wrapping.
- When undefined: low-W-bit truncation (wrap).
- Register timing and reset values are identical in both builds.

Test Plan:
- Reset check: hold rst=0 with random inputs -> all outputs 0 and e_valid=0. Assert rst=0 mid-run -> outputs clear without waiting for clk.
- Mismatched coefficients: y_init=0, a_hat=b_hat=0, x_last sequence 2,1,2 on successive edges ->
  - edge1: y_cur=4, y_hat=0, e=0, e_valid=0
  - edge2: y_last=4, y_cur=6, e=4, e_valid=1
  - edge3: y_cur=10, e=6
- Matched coefficients: a_hat=1, b_hat=2, y_init=0, x_last alternating 2,1 -> y_hat==y_cur each cycle; e=0 while e_valid=1.
- Initial condition: y_init=3, x_last=0, a_hat=0, b_hat=0 -> edge1: y_last=3, y_cur=3. edge2: y_last=3, y_cur=3, e=3. Changing y_init after edge1 has no effect.
- Overflow: y_init=0, x_last=100 held, a_hat=b_hat=0 -> edge1: y_cur=200 wraps to -56; with CALC_ERR_SAT_EN, y_cur=127. Following error: e=-56 (wrap build) / e=127 (sat build).
- Mixed coefficients: a_hat=2, b_hat=1, x_last alternating 2/1, y_init=0 -> e equals the bit-exact model value y_cur(prev) - y_hat(prev) every cycle.
